// File: rtl/zom_spawn_scheduler_if.sv
// Signal bundle between game control (master) and the zombie spawn scheduler (slave).
interface zom_spawn_scheduler_if #(
  parameter int unsigned NUM_SLOTS = 10,
  parameter int unsigned ROWS      = 5,
  parameter int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic                 frame_tick;
  logic                 game_run;
  logic [NUM_SLOTS-1:0] zom_live;
  logic [NUM_SLOTS-1:0] spawn_req;
  logic [ROW_W-1:0]     spawn_row;
  logic [3:0]           wave;
  logic                 wave_done;
  logic                 busy;

  modport master (
    output frame_tick, game_run, zom_live,
    input  spawn_req, spawn_row, wave, wave_done, busy
  );

  modport slave (
    input  frame_tick, game_run, zom_live,
    output spawn_req, spawn_row, wave, wave_done, busy
  );
endinterface

// File: rtl/zom_spawn_scheduler.sv
// Paces zombie spawns in waves, grants the lowest free slot and waits for it to go live.
// Define ZOM_SCHED_RANDROW_EN for LFSR-chosen rows; default is a round-robin row counter.
module zom_spawn_scheduler #(
  parameter int unsigned NUM_SLOTS      = 10,
  parameter int unsigned ROWS           = 5,
  parameter int unsigned WAVE_SIZE      = 6,
  parameter int unsigned SPAWN_INTERVAL = 120,
  parameter int unsigned INTERVAL_STEP  = 10,
  parameter int unsigned MIN_INTERVAL   = 30,
  parameter int unsigned WAVE_GAP       = 180,
  parameter int unsigned ACK_TIMEOUT    = 16
) (
  input logic                  MAX10_CLK1_50,
  input logic                  Reset,
  zom_spawn_scheduler_if.slave bus
);
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned SPN_W = $clog2(WAVE_SIZE + 1);
  localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PICK, S_ISSUE, S_ACK, S_GAP} state_e;

  state_e               state_q, state_d;
  logic [3:0]           wave_q, wave_d;
  logic [SPN_W-1:0]     spawned_q, spawned_d;
  logic [15:0]          timer_q, timer_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ACK_W-1:0]     ack_cnt_q, ack_cnt_d;
  logic [NUM_SLOTS-1:0] spawn_req_q, spawn_req_d;
  logic [ROW_W-1:0]     spawn_row_q, spawn_row_d;
  logic                 wave_done_q, wave_done_d;
  logic                 busy_q, busy_d;
`ifdef ZOM_SCHED_RANDROW_EN
  logic [7:0]           lfsr_q, lfsr_d;
`else
  logic [ROW_W-1:0]     row_q, row_d;
`endif
  logic [ROW_W-1:0]     pick_row;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;

  // Clamp before subtracting so late waves never wrap below the floor.
  function automatic logic [15:0] interval_of(input logic [3:0] w);
    logic [15:0] dec;
    logic [15:0] head;
    dec  = (16'(w) - 16'd1) * 16'(INTERVAL_STEP);
    head = (SPAWN_INTERVAL > MIN_INTERVAL) ? 16'(SPAWN_INTERVAL - MIN_INTERVAL) : '0;
    return (dec >= head) ? 16'(MIN_INTERVAL) : (16'(SPAWN_INTERVAL) - dec);
  endfunction

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!bus.zom_live[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wave_d      = wave_q;
    spawned_d   = spawned_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    ack_cnt_d   = ack_cnt_q;
    spawn_req_d = '0;
    spawn_row_d = '0;
    wave_done_d = 1'b0;
`ifdef ZOM_SCHED_RANDROW_EN
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    pick_row = ROW_W'(lfsr_q % 8'(ROWS));
`else
    row_d    = row_q;
    pick_row = row_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.game_run) begin
          state_d   = S_WAIT;
          wave_d    = 4'd1;
          spawned_d = '0;
          timer_d   = 16'(SPAWN_INTERVAL);
        end
      end
      S_WAIT: begin
        if (bus.frame_tick && timer_q != '0) timer_d = timer_q - 16'd1;
        if (spawned_q == SPN_W'(WAVE_SIZE) && bus.zom_live == '0) begin
          state_d     = S_GAP;
          wave_done_d = 1'b1;
          timer_d     = 16'(WAVE_GAP);
        end else if (timer_q == '0 && spawned_q < SPN_W'(WAVE_SIZE)) begin
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (free_found) begin
          state_d     = S_ISSUE;
          idx_d       = free_idx;
          spawn_req_d = NUM_SLOTS'(1) << free_idx;
          spawn_row_d = pick_row;
        end else begin
          state_d = S_WAIT;
          timer_d = 16'd1;
        end
      end
      S_ISSUE: begin
        state_d   = S_ACK;
        ack_cnt_d = '0;
      end
      S_ACK: begin
        if (bus.zom_live[idx_q]) begin
          state_d   = S_WAIT;
          spawned_d = spawned_q + SPN_W'(1);
          timer_d   = interval_of(wave_q);
`ifndef ZOM_SCHED_RANDROW_EN
          row_d     = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
`endif
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          state_d = S_WAIT;
          timer_d = 16'd1;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      S_GAP: begin
        if (bus.frame_tick && timer_q != '0) timer_d = timer_q - 16'd1;
        if (timer_q == '0) begin
          state_d   = S_WAIT;
          wave_d    = (wave_q == 4'd15) ? 4'd15 : wave_q + 4'd1;
          spawned_d = '0;
          timer_d   = interval_of(wave_d);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving play overrides everything, including a spawn about to be issued.
    if (!bus.game_run) begin
      state_d     = S_IDLE;
      wave_d      = '0;
      spawned_d   = '0;
      timer_d     = '0;
      spawn_req_d = '0;
      spawn_row_d = '0;
      wave_done_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      wave_q      <= '0;
      spawned_q   <= '0;
      timer_q     <= '0;
      idx_q       <= '0;
      ack_cnt_q   <= '0;
      spawn_req_q <= '0;
      spawn_row_q <= '0;
      wave_done_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ZOM_SCHED_RANDROW_EN
      lfsr_q      <= 8'hA5;
`else
      row_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wave_q      <= wave_d;
      spawned_q   <= spawned_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      ack_cnt_q   <= ack_cnt_d;
      spawn_req_q <= spawn_req_d;
      spawn_row_q <= spawn_row_d;
      wave_done_q <= wave_done_d;
      busy_q      <= busy_d;
`ifdef ZOM_SCHED_RANDROW_EN
      lfsr_q      <= lfsr_d;
`else
      row_q       <= row_d;
`endif
    end
  end

  assign bus.spawn_req = spawn_req_q;
  assign bus.spawn_row = spawn_row_q;
  assign bus.wave      = wave_q;
  assign bus.wave_done = wave_done_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_zom_spawn_scheduler.sv
// Directed bench for zom_spawn_scheduler, default (round-robin row) build.
module tb_zom_spawn_scheduler;
  localparam int unsigned NUM_SLOTS = 10;
  localparam int unsigned ROWS      = 5;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_row  = 0;

  always #5 clk = ~clk;

  zom_spawn_scheduler_if #(.NUM_SLOTS(NUM_SLOTS), .ROWS(ROWS)) bus ();

  zom_spawn_scheduler #(.NUM_SLOTS(NUM_SLOTS), .ROWS(ROWS)) dut (
    .MAX10_CLK1_50(clk),
    .Reset        (rst),
    .bus          (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned model_interval(input int unsigned w);
    int v;
    v = 120 - 10 * (int'(w) - 1);
    return (v < 30) ? 30 : int'(v);
  endfunction

  // Ticks every 'period' clocks until spawn_req appears or the budget runs out.
  task automatic wait_req(input int unsigned period, input int unsigned budget,
                          output logic found, output int unsigned ticks);
    found = 1'b0;
    ticks = 0;
    for (int unsigned c = 1; c <= budget && !found; c++) begin
      bus.frame_tick = ((c % period) == 0);
      if (bus.frame_tick) ticks++;
      step();
      if (bus.spawn_req != '0) found = 1'b1;
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic spawn_ack(input string tag, input int unsigned exp_ticks, input int unsigned slot);
    logic        found;
    int unsigned ticks;
    wait_req(4, 4 * (exp_ticks + 4) + 8, found, ticks);
    check_eq({tag, "_found"}, 32'(found), 32'd1);
    check_eq({tag, "_ticks"}, ticks, exp_ticks);
    check_eq({tag, "_req"}, 32'(bus.spawn_req), 32'd1 << slot);
    check_eq({tag, "_row"}, 32'(bus.spawn_row), exp_row);
    bus.zom_live[slot] = 1'b1;
    step();
    check_eq({tag, "_pulse"}, 32'(bus.spawn_req), 32'd0);
    step();
    exp_row = (exp_row + 1) % ROWS;
  endtask

  task automatic end_wave(input string tag);
    step();
    check_eq({tag, "_early_done"}, 32'(bus.wave_done), 32'd0);
    bus.zom_live = '0;
    step();
    check_eq({tag, "_done"}, 32'(bus.wave_done), 32'd1);
    step();
    check_eq({tag, "_done_pulse"}, 32'(bus.wave_done), 32'd0);
  endtask

  task automatic run_wave(input int unsigned n);
    int unsigned eff;
    eff = (n > 15) ? 15 : n;
    spawn_ack($sformatf("w%0d_s0", n), 180 + model_interval(eff), 0);
    check_eq($sformatf("w%0d_num", n), 32'(bus.wave), eff);
    for (int unsigned s = 1; s < 6; s++)
      spawn_ack($sformatf("w%0d_s%0d", n, s), model_interval(eff), s);
    end_wave($sformatf("w%0d", n));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_req"},  32'(bus.spawn_req), 32'd0);
    check_eq({tag, "_wave"}, 32'(bus.wave), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic        found;
    int unsigned ticks;

    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.game_run   = 1'b0;
    bus.zom_live   = '0;
    repeat (3) step();
    check_eq("rst_req",  32'(bus.spawn_req), 32'd0);
    check_eq("rst_row",  32'(bus.spawn_row), 32'd0);
    check_eq("rst_wave", 32'(bus.wave), 32'd0);
    check_eq("rst_done", 32'(bus.wave_done), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    bus.game_run = 1'b1;
    step();
    check_eq("rst_wins_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    step();
    check_eq("start_busy", 32'(bus.busy), 32'd1);
    check_eq("start_wave", 32'(bus.wave), 32'd1);

    // Wave 1: first spawn, then slot 3 ignoring its grant until timeout.
    spawn_ack("w1_first", 120, 0);
    bus.zom_live = 10'h007;
    wait_req(4, 4 * 124 + 8, found, ticks);
    check_eq("to_found", 32'(found), 32'd1);
    check_eq("to_ticks", ticks, 32'd120);
    check_eq("to_req",   32'(bus.spawn_req), 32'h008);
    check_eq("to_row",   32'(bus.spawn_row), exp_row);
    repeat (16) step();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick  = 1'b0;
    bus.zom_live[3] = 1'b1;
    step();
    bus.zom_live[3] = 1'b0;
    spawn_ack("to_retry", 1, 3);

    // All slots busy at expiry: retried every frame, granted once slot 7 frees.
    bus.zom_live = 10'h3FF;
    wait_req(4, 486, found, ticks);
    check_eq("full_no_req", 32'(found), 32'd0);
    bus.zom_live = 10'h37F;
    spawn_ack("full_slot7", 1, 7);

    bus.zom_live = '0;
    for (int unsigned s = 0; s < 3; s++) spawn_ack($sformatf("w1_s%0d", s + 3), 120, s);
    end_wave("w1");

    for (int unsigned n = 2; n <= 16; n++) run_wave(n);

    // game_run dropped in GAP, in ACK, on the PICK->ISSUE clock and during ISSUE.
    bus.game_run = 1'b0;
    step();
    check_idle("drop_gap");
    bus.game_run = 1'b1;
    step();
    check_eq("restart_wave", 32'(bus.wave), 32'd1);
    wait_req(4, 4 * 124, found, ticks);
    check_eq("restart_ticks", ticks, 32'd120);
    step();
    bus.game_run = 1'b0;
    step();
    check_idle("drop_ack");
    bus.game_run = 1'b1;
    step();
    wait_req(4, 481, found, ticks);
    check_eq("pre_issue_no_req", 32'(found), 32'd0);
    bus.game_run = 1'b0;
    step();
    check_idle("drop_pick");
    bus.game_run = 1'b1;
    step();
    wait_req(4, 4 * 124, found, ticks);
    check_eq("issue_req", 32'(bus.spawn_req), 32'h001);
    bus.game_run = 1'b0;
    step();
    check_idle("drop_issue");
    check_eq("drop_issue_done", 32'(bus.wave_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
